mux_nx1_pipe: RTL and testbench

//   Parametrised N-input, WIDTH-bit operand select mux with registered output and a

---
 rtl/mux_nx1_pipe.sv | 121 ++++++++++++
 tb/tb_mux_nx1_pipe.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mux_nx1_pipe.sv
// N-input operand select mux. The selected beat is registered and sent out through a
// valid/ready handshake, with a 2-entry skid buffer.
module mux_nx1_pipe #(
   parameter  int WIDTH = 24,
   parameter  int N     = 3,
   localparam int SEL_W = $clog2(N)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N*WIDTH-1:0] in_data,
   input  logic [SEL_W-1:0]   sel,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               flush,
   output logic [WIDTH-1:0]   out_data,
   output logic               out_err,
   output logic               out_valid,
   input  logic               out_ready
);

   typedef enum logic [1:0] {
      EMPTY,
      ONE,
      TWO
   } state_t;

   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic             err;
   } beat_t;

   localparam logic [SEL_W:0] N_EXT = (SEL_W+1)'(N);

   state_t state;
   state_t state_nxt;
   beat_t  in_beat;
   beat_t  out_q;
   beat_t  skid_q;
   logic   in_fire;
   logic   out_fire;
   logic   load_out;
   logic   load_skid;
   logic   from_skid;

   // Select and range check happen on entry so each stored beat is final.
   always_comb begin
      in_beat = '0;
      if ({1'b0, sel} >= N_EXT) begin
         in_beat.err = 1'b1;
      end else begin
         for (int k = 0; k < N; k++) begin
            if (sel == SEL_W'(k)) begin
               in_beat.data = in_data[k*WIDTH +: WIDTH];
            end
         end
      end
   end

   assign out_valid = (state != EMPTY);
   assign in_ready  = (state != TWO);
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = out_valid & out_ready;
   assign out_data  = out_q.data;
   assign out_err   = out_q.err;

   always_comb begin
      state_nxt = state;
      load_out  = 1'b0;
      load_skid = 1'b0;
      from_skid = 1'b0;
      if (flush) begin
         state_nxt = EMPTY;
      end else begin
         case (state)
            EMPTY: begin
               if (in_fire) begin
                  state_nxt = ONE;
                  load_out  = 1'b1;
               end
            end
            ONE: begin
               if (in_fire && out_fire) begin
                  load_out = 1'b1;
               end else if (in_fire) begin
                  state_nxt = TWO;
                  load_skid = 1'b1;
               end else if (out_fire) begin
                  state_nxt = EMPTY;
               end
            end
            TWO: begin
               if (out_fire) begin
                  state_nxt = ONE;
                  load_out  = 1'b1;
                  from_skid = 1'b1;
               end
            end
            default: begin
               state_nxt = EMPTY;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= EMPTY;
         out_q  <= '0;
         skid_q <= '0;
      end else begin
         state <= state_nxt;
         if (load_out) begin
            out_q <= from_skid ? skid_q : in_beat;
         end
         if (load_skid) begin
            skid_q <= in_beat;
         end
      end
   end

endmodule

// File: tb/tb_mux_nx1_pipe.sv
// Bench for mux_nx1_pipe: directed cases on a 24-bit 3-input instance and
// random traffic on a 32-bit 5-input instance against a queue model.
module tb_mux_nx1_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h want %h", tag, got, exp);
   endtask

   // 24-bit, 3-input instance
   logic        a_rst = 1'b1;
   logic [71:0] a_in_data = '0;
   logic [1:0]  a_sel = '0;
   logic        a_in_valid = 1'b0;
   logic        a_in_ready;
   logic        a_flush = 1'b0;
   logic [23:0] a_out_data;
   logic        a_out_err;
   logic        a_out_valid;
   logic        a_out_ready = 1'b0;

   mux_nx1_pipe #(.WIDTH(24), .N(3)) dut_a (
      .clk(clk), .rst(a_rst), .in_data(a_in_data), .sel(a_sel),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .flush(a_flush),
      .out_data(a_out_data), .out_err(a_out_err),
      .out_valid(a_out_valid), .out_ready(a_out_ready)
   );

   // 32-bit, 5-input instance
   logic         b_rst = 1'b1;
   logic [159:0] b_in_data = '0;
   logic [2:0]   b_sel = '0;
   logic         b_in_valid = 1'b0;
   logic         b_in_ready;
   logic         b_flush = 1'b0;
   logic [31:0]  b_out_data;
   logic         b_out_err;
   logic         b_out_valid;
   logic         b_out_ready = 1'b0;

   mux_nx1_pipe #(.WIDTH(32), .N(5)) dut_b (
      .clk(clk), .rst(b_rst), .in_data(b_in_data), .sel(b_sel),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .flush(b_flush),
      .out_data(b_out_data), .out_err(b_out_err),
      .out_valid(b_out_valid), .out_ready(b_out_ready)
   );

   typedef struct {
      logic [31:0] d;
      logic        e;
   } beat_t;

   beat_t       q[$];
   logic [31:0] w[5];
   logic [23:0] exp_a[4];
   logic        exp_e[4];

   initial begin
      exp_a[0] = 24'hAAAAAA; exp_e[0] = 1'b0;
      exp_a[1] = 24'hBBBBBB; exp_e[1] = 1'b0;
      exp_a[2] = 24'hCCCCCC; exp_e[2] = 1'b0;
      exp_a[3] = 24'h000000; exp_e[3] = 1'b1;

      repeat (2) @(negedge clk);
      chk("rst_valid", 64'(a_out_valid), 64'(0));
      chk("rst_data", 64'(a_out_data), 64'(0));
      chk("rst_err", 64'(a_out_err), 64'(0));
      chk("rst_ready", 64'(a_in_ready), 64'(1));
      chk("rst_b_valid", 64'(b_out_valid), 64'(0));
      chk("rst_b_ready", 64'(b_in_ready), 64'(1));
      a_rst = 1'b0;

      // select sweep including out-of-range sel
      a_in_data = {24'hCCCCCC, 24'hBBBBBB, 24'hAAAAAA};
      a_out_ready = 1'b1;
      a_in_valid = 1'b1;
      for (int s = 0; s < 4; s++) begin
         a_sel = 2'(s);
         @(negedge clk);
         chk($sformatf("sel%0d_data", s), 64'(a_out_data), 64'(exp_a[s]));
         chk($sformatf("sel%0d_err", s), 64'(a_out_err), 64'(exp_e[s]));
         chk($sformatf("sel%0d_valid", s), 64'(a_out_valid), 64'(1));
      end
      a_in_valid = 1'b0;
      @(negedge clk);
      chk("sweep_drain", 64'(a_out_valid), 64'(0));

      // backpressure
      a_out_ready = 1'b0;
      a_sel = 2'd0;
      a_in_valid = 1'b1;
      a_in_data[23:0] = 24'h123456;
      @(negedge clk);
      chk("bp_rdy1", 64'(a_in_ready), 64'(1));
      chk("bp_d1", 64'(a_out_data), 64'h123456);
      a_in_data[23:0] = 24'h789ABC;
      @(negedge clk);
      a_in_valid = 1'b0;
      chk("bp_rdy2", 64'(a_in_ready), 64'(0));
      chk("bp_hold", 64'(a_out_data), 64'h123456);
      @(negedge clk);
      chk("bp_hold2", 64'(a_out_data), 64'h123456);
      a_out_ready = 1'b1;
      @(negedge clk);
      chk("bp_d2", 64'(a_out_data), 64'h789ABC);
      chk("bp_v2", 64'(a_out_valid), 64'(1));
      @(negedge clk);
      chk("bp_empty", 64'(a_out_valid), 64'(0));

      // streaming
      a_sel = 2'd1;
      a_in_valid = 1'b1;
      for (int i = 0; i < 16; i++) begin
         a_in_data[47:24] = 24'(i + 24'h100);
         chk("str_rdy", 64'(a_in_ready), 64'(1));
         @(negedge clk);
         chk($sformatf("str%0d", i), 64'(a_out_data), 64'(i + 24'h100));
         chk("str_v", 64'(a_out_valid), 64'(1));
      end
      a_in_valid = 1'b0;
      @(negedge clk);

      // flush in TWO with in_valid high
      a_out_ready = 1'b0;
      a_in_valid = 1'b1;
      a_in_data[47:24] = 24'h111111;
      @(negedge clk);
      a_in_data[47:24] = 24'h222222;
      @(negedge clk);
      chk("fl_two", 64'(a_in_ready), 64'(0));
      a_in_data[47:24] = 24'h333333;
      a_flush = 1'b1;
      @(negedge clk);
      a_flush = 1'b0;
      a_in_valid = 1'b0;
      chk("fl_valid", 64'(a_out_valid), 64'(0));
      chk("fl_ready", 64'(a_in_ready), 64'(1));
      a_out_ready = 1'b1;
      @(negedge clk);
      chk("fl_gone", 64'(a_out_valid), 64'(0));

      // reset mid-stream in ONE
      a_out_ready = 1'b0;
      a_sel = 2'd2;
      a_in_valid = 1'b1;
      @(negedge clk);
      chk("mr_one", 64'(a_out_data), 64'hCCCCCC);
      a_in_valid = 1'b0;
      a_rst = 1'b1;
      @(negedge clk);
      a_rst = 1'b0;
      chk("mr_valid", 64'(a_out_valid), 64'(0));
      chk("mr_data", 64'(a_out_data), 64'(0));
      chk("mr_err", 64'(a_out_err), 64'(0));
      chk("mr_ready", 64'(a_in_ready), 64'(1));

      // random traffic, queue model
      b_rst = 1'b0;
      begin
         logic        hold = 1'b0;
         logic [31:0] hd = '0;
         logic        he = 1'b0;
         for (int c = 0; c < 10000; c++) begin
            bit    ifire;
            bit    ofire;
            beat_t nb;
            chk("rnd_valid", 64'(b_out_valid), 64'(q.size() != 0));
            chk("rnd_ready", 64'(b_in_ready), 64'(q.size() < 2));
            if (hold) begin
               chk("rnd_stab_d", 64'(b_out_data), 64'(hd));
               chk("rnd_stab_e", 64'(b_out_err), 64'(he));
            end
            for (int k = 0; k < 5; k++) begin
               w[k] = $urandom;
               b_in_data[k*32 +: 32] = w[k];
            end
            b_sel = 3'($urandom_range(0, 7));
            b_in_valid = ($urandom % 4) != 0;
            b_out_ready = ($urandom % 3) != 0;
            b_flush = ($urandom % 64) == 0;
            ofire = (q.size() > 0) && b_out_ready;
            ifire = b_in_valid && (q.size() < 2);
            if (ofire) begin
               chk("rnd_data", 64'(b_out_data), 64'(q[0].d));
               chk("rnd_err", 64'(b_out_err), 64'(q[0].e));
               void'(q.pop_front());
            end
            if (ifire && !b_flush) begin
               nb.e = (b_sel >= 3'd5);
               nb.d = nb.e ? 32'h0 : w[b_sel];
               q.push_back(nb);
            end
            if (b_flush) q.delete();
            hold = (q.size() > 0 || ofire) ? (b_out_valid && !b_out_ready) : 1'b0;
            hd = b_out_data;
            he = b_out_err;
            @(negedge clk);
         end
      end
      b_flush = 1'b0;
      b_in_valid = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
